// File: rtl/scalar_to_axi_stream.sv
// Scalar sample strobe -> FIFO -> AXI4-Stream packets of PKT_LEN beats, zero-padded on stop.
// Optional dropped-sample counter: define S2AXIS_OVF_COUNT_EN.
module scalar_to_axi_stream #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 16,
  parameter int PKT_LEN      = 64
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          enable,
  input  logic [SAMPLE_WIDTH-1:0]       sample_in,
  input  logic                          sample_valid,
  input  logic                          ovf_clr,
  output logic [DATA_WIDTH-1:0]         M_AXIS_TDATA,
  output logic                          M_AXIS_TVALID,
  input  logic                          M_AXIS_TREADY,
  output logic                          M_AXIS_TLAST,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [15:0]                   ovf_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(PKT_LEN);
  localparam logic [CW-1:0] LAST = CW'(PKT_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAD
  } state_t;

  state_t state;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic [CW-1:0]         beat_cnt;

  logic                  full;
  logic                  empty;
  logic                  hs;
  logic                  out_free;
  logic                  accept;
  logic                  push;
  logic                  drop;
  logic                  pop;
  logic                  pad_load;
  logic                  drained;
  logic [CW-1:0]         cnt_n;
  logic [DATA_WIDTH-1:0] ext;

  always_comb begin
    full     = (count == (AW+1)'(FIFO_DEPTH));
    empty    = (count == '0);
    hs       = M_AXIS_TVALID && M_AXIS_TREADY;
    out_free = !M_AXIS_TVALID || hs;
    accept   = (state == RUN) && enable && sample_valid;
    push     = accept && !full;
    drop     = accept && full;
    pop      = (state == RUN) && out_free && !empty;
    // stop loading pad beats once the TLAST beat is leaving
    pad_load = (state == PAD) && out_free && !(hs && M_AXIS_TLAST);
    drained  = !enable && empty && !M_AXIS_TVALID;
    ext      = DATA_WIDTH'($signed(sample_in));
    cnt_n    = beat_cnt;
    if (hs) begin
      cnt_n = (beat_cnt == LAST) ? '0 : beat_cnt + CW'(1);
    end
  end

  always_ff @(posedge ACLK) begin
    if (push) begin
      mem[wr_ptr] <= ext;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      beat_cnt      <= '0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TLAST  <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + (AW+1)'(1);
      end else if (pop && !push) begin
        count <= count - (AW+1)'(1);
      end

      beat_cnt <= cnt_n;

      if (pop) begin
        M_AXIS_TDATA  <= mem[rd_ptr];
        M_AXIS_TVALID <= 1'b1;
        M_AXIS_TLAST  <= (cnt_n == LAST);
      end else if (pad_load) begin
        M_AXIS_TDATA  <= '0;
        M_AXIS_TVALID <= 1'b1;
        M_AXIS_TLAST  <= (cnt_n == LAST);
      end else if (hs) begin
        M_AXIS_TVALID <= 1'b0;
        M_AXIS_TLAST  <= 1'b0;
      end

      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (enable) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (drained) begin
            state <= (beat_cnt == '0) ? IDLE : PAD;
          end
        end
        PAD: begin
          if (hs && M_AXIS_TLAST) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fifo_level = count;

`ifdef S2AXIS_OVF_COUNT_EN
  logic [15:0] ovf_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ovf_q <= '0;
    end else if (drop) begin
      if (ovf_q != 16'hFFFF) begin
        ovf_q <= ovf_q + 16'd1;
      end
    end else if (ovf_clr) begin
      ovf_q <= '0;
    end
  end

  assign ovf_cnt = ovf_q;
`else
  assign ovf_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_scalar_to_axi_stream.sv
// Bench for scalar_to_axi_stream: vector table, scoreboard queue, pad and backpressure sequences.
// Build with S2AXIS_OVF_COUNT_EN defined to expect a live ovf_cnt.
module tb_scalar_to_axi_stream;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        enable;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        ovf_clr;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TREADY;
  logic        M_AXIS_TLAST;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic [15:0] ovf_cnt;

  scalar_to_axi_stream #(
    .SAMPLE_WIDTH(16),
    .DATA_WIDTH  (32),
    .FIFO_DEPTH  (4),
    .PKT_LEN     (4)
  ) dut (
    .ACLK         (ACLK),
    .ARESETN      (ARESETN),
    .enable       (enable),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .ovf_clr      (ovf_clr),
    .M_AXIS_TDATA (M_AXIS_TDATA),
    .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TREADY(M_AXIS_TREADY),
    .M_AXIS_TLAST (M_AXIS_TLAST),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .ovf_cnt      (ovf_cnt)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [15:0] sample;
    logic [31:0] data;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t q[$];
  vec_t  tbl[12];
  int    checks = 0;
  int    errors = 0;
  int    model_cnt = 0;
  bit    rand_ready = 1'b0;

`ifdef S2AXIS_OVF_COUNT_EN
  localparam logic [15:0] EXP_OVF = 16'd2;
`else
  localparam logic [15:0] EXP_OVF = 16'd0;
`endif

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] d);
    beat_t b;
    b.data = d;
    b.last = (model_cnt == 3);
    q.push_back(b);
    model_cnt = (model_cnt + 1) % 4;
  endtask

  task automatic push_pads();
    while (model_cnt != 0) push_exp(32'h0);
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
    if (rand_ready) M_AXIS_TREADY = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || M_AXIS_TVALID) && n < 1000) begin
      step();
      n++;
    end
    check("drain_done", 32'(n < 1000), 32'd1);
  endtask

  // scoreboard + AXIS hold checks
  logic        p_valid = 1'b0;
  logic        p_ready = 1'b0;
  logic [31:0] p_data  = '0;
  logic        p_last  = 1'b0;

  always @(negedge ACLK) begin
    if (ARESETN === 1'b1) begin
      if (p_valid && !p_ready) begin
        check("hold_valid", 32'(M_AXIS_TVALID), 32'd1);
        check("hold_data", M_AXIS_TDATA, p_data);
        check("hold_last", 32'(M_AXIS_TLAST), 32'(p_last));
      end
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        if (q.size() == 0) begin
          check("unexpected_beat", M_AXIS_TDATA, 32'hDEAD_BEEF);
        end else begin
          beat_t b;
          b = q.pop_front();
          check("beat_data", M_AXIS_TDATA, b.data);
          check("beat_last", 32'(M_AXIS_TLAST), 32'(b.last));
        end
      end
    end
    p_valid = M_AXIS_TVALID;
    p_ready = M_AXIS_TREADY;
    p_data  = M_AXIS_TDATA;
    p_last  = M_AXIS_TLAST;
  end

  initial begin
    int sent;
    int guard;
    for (int i = 0; i < 8; i++) tbl[i] = '{16'(i + 1), 32'(i + 1)};
    tbl[8]  = '{16'h8000, 32'hFFFF_8000};
    tbl[9]  = '{16'h7FFF, 32'h0000_7FFF};
    tbl[10] = '{16'hFFFF, 32'hFFFF_FFFF};
    tbl[11] = '{16'h1234, 32'h0000_1234};

    // T1 reset
    ARESETN = 1'b0;
    enable = 1'b0;
    sample_in = 16'h5555;
    sample_valid = 1'b1;
    ovf_clr = 1'b0;
    M_AXIS_TREADY = 1'b1;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_tvalid", 32'(M_AXIS_TVALID), 32'd0);
    check("rst_tlast", 32'(M_AXIS_TLAST), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
    step();
    ARESETN = 1'b1;
    repeat (3) step();
    @(negedge ACLK);
    check("idle_tvalid", 32'(M_AXIS_TVALID), 32'd0);
    check("idle_level", 32'(fifo_level), 32'd0);
    step();
    sample_valid = 1'b0;

    // T2/T3 table
    enable = 1'b1;
    step();
    for (int i = 0; i < 12; i++) begin
      sample_in = tbl[i].sample;
      sample_valid = 1'b1;
      push_exp(tbl[i].data);
      @(negedge ACLK);
      if (i < 3) check("latency", 32'(M_AXIS_TVALID), 32'(i == 2));
      step();
    end
    sample_valid = 1'b0;
    drain();

    // T4 overflow
    M_AXIS_TREADY = 1'b0;
    for (int i = 0; i < 7; i++) begin
      sample_in = 16'h0100 + 16'(i);
      sample_valid = 1'b1;
      if (i < 5) push_exp(32'h0100 + 32'(i));
      step();
    end
    sample_valid = 1'b0;
    step();
    @(negedge ACLK);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_cnt", 32'(ovf_cnt), 32'(EXP_OVF));
    check("ovf_level", 32'(fifo_level), 32'd4);
    check("ovf_head_valid", 32'(M_AXIS_TVALID), 32'd1);
    step();
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    @(negedge ACLK);
    check("clr_flag", 32'(overflow), 32'd0);
    check("clr_cnt", 32'(ovf_cnt), 32'd0);
    check("clr_level", 32'(fifo_level), 32'd4);
    step();
    M_AXIS_TREADY = 1'b1;
    enable = 1'b0;
    push_pads();
    drain();

    // T5 pad after two samples; strobe while stopping is ignored
    enable = 1'b1;
    step();
    sample_in = 16'h00AA;
    sample_valid = 1'b1;
    push_exp(32'h0000_00AA);
    step();
    sample_in = 16'h00BB;
    push_exp(32'h0000_00BB);
    step();
    enable = 1'b0;
    sample_in = 16'h00CC;
    push_pads();
    step();
    sample_valid = 1'b0;
    drain();
    sample_valid = 1'b1;
    repeat (3) step();
    @(negedge ACLK);
    check("post_pad_tvalid", 32'(M_AXIS_TVALID), 32'd0);
    check("post_pad_level", 32'(fifo_level), 32'd0);
    check("post_pad_ovf", 32'(overflow), 32'd0);
    step();
    sample_valid = 1'b0;

    // T6 random backpressure, 3 packets
    rand_ready = 1'b1;
    enable = 1'b1;
    step();
    sent = 0;
    guard = 0;
    while (sent < 12 && guard < 2000) begin
      if (fifo_level < 3 && $urandom_range(0, 1) == 1) begin
        sample_in = 16'($urandom);
        sample_valid = 1'b1;
        push_exp(32'($signed(sample_in)));
        sent++;
      end else begin
        sample_valid = 1'b0;
      end
      step();
      guard++;
    end
    sample_valid = 1'b0;
    check("bp_sent", 32'(sent), 32'd12);
    drain();
    rand_ready = 1'b0;
    M_AXIS_TREADY = 1'b1;
    repeat (2) step();
    check("queue_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
